// File: rtl/data_mem_responder.sv
// Data-RAM responder for the multi-cycle CPU: big-endian 32-bit word reads and
// writes with a fixed number of wait states and a one-cycle ready pulse.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | no access in flight; accepts a strobe and latches the request
// S_WAIT   | counting wait states; drops back to S_IDLE if the strobe is released
// S_ACCESS | ready pulse; a good write commits at the end of this cycle
// S_DONE   | access finished; waits for both strobes high before re-arming
module data_mem_responder #(
  parameter int DEPTH_BYTES = 128,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        _RD,
  input  logic        _WR,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic            is_wr_q;
  logic [7:0]      mem [DEPTH_BYTES];

  logic            in_idle;
  logic            req;
  logic            strobe_lost;
  logic            enter_access;
  logic [31:0]     acc_addr;
  logic            acc_wr;
  logic            acc_bad;
  logic [AW-1:0]   rd_base;
  logic [AW-1:0]   wr_base;
  logic [31:0]     rd_word;

  assign in_idle     = (state_q == S_IDLE);
  assign req         = !_RD || !_WR;
  assign strobe_lost = is_wr_q ? _WR : _RD;

  // With zero wait states the access is entered straight from IDLE, so the
  // error check and read path must look at the live request, not the latch.
  assign acc_addr = in_idle ? addr : addr_q;
  assign acc_wr   = in_idle ? !_WR : is_wr_q;
  assign acc_bad  = (acc_addr[1:0] != 2'b00) ||
                    (({1'b0, acc_addr} + 33'd3) >= 33'(DEPTH_BYTES));

  assign rd_base = acc_addr[AW-1:0];
  assign wr_base = addr_q[AW-1:0];
  assign rd_word = {mem[rd_base], mem[rd_base + AW'(1)],
                    mem[rd_base + AW'(2)], mem[rd_base + AW'(3)]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req) state_d = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT: begin
        if (strobe_lost)            state_d = S_IDLE;
        else if (cnt_q == CW'(1))   state_d = S_ACCESS;
      end
      S_ACCESS: state_d = S_DONE;
      S_DONE:   if (_RD && _WR) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign enter_access = (state_d == S_ACCESS) && (state_q != S_ACCESS);
  assign ready        = (state_q == S_ACCESS);
  assign busy         = !in_idle;

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
      for (int i = 0; i < DEPTH_BYTES; i++) mem[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      if (in_idle && req) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        is_wr_q <= !_WR;
        cnt_q   <= CW'(WAIT_STATES);
        err     <= 1'b0;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (enter_access) begin
        if (acc_bad)      err   <= 1'b1;
        else if (!acc_wr) rdata <= rd_word;
      end
      // err was registered on entry to ACCESS, so it gates the commit here
      if (ready && is_wr_q && !err) begin
        mem[wr_base]          <= wdata_q[31:24];
        mem[wr_base + AW'(1)] <= wdata_q[23:16];
        mem[wr_base + AW'(2)] <= wdata_q[15:8];
        mem[wr_base + AW'(3)] <= wdata_q[7:0];
      end
    end
  end

endmodule
